// File: rtl/double_dabble_sequencer_if.sv
// Start/busy/done handshake and result bus of the double dabble sequencer.
interface double_dabble_sequencer_if #(
    parameter int unsigned INPUT_BITS = 16,
    parameter int unsigned DIGITS     = 5
);
    logic                    start_i;
    logic [INPUT_BITS-1:0]   binary_i;
    logic                    busy_o;
    logic                    done_o;
    logic [4*DIGITS-1:0]     bcd_o;
    logic [DIGITS-1:0]       blank_o;

    // Requester side: issues operands, observes results.
    modport master (
        output start_i,
        output binary_i,
        input  busy_o,
        input  done_o,
        input  bcd_o,
        input  blank_o
    );

    // Converter side.
    modport slave (
        input  start_i,
        input  binary_i,
        output busy_o,
        output done_o,
        output bcd_o,
        output blank_o
    );
endinterface

// File: rtl/double_dabble_sequencer.sv
// Sequential binary-to-BCD converter: one shift-and-add-3 iteration per clock,
// with a leading-zero blanking mask for 7-segment drivers.
module double_dabble_sequencer #(
    parameter int unsigned INPUT_BITS = 16,
    parameter int unsigned DIGITS     = 5
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    double_dabble_sequencer_if.slave bus
);
    localparam int unsigned SW   = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(INPUT_BITS + 1);
    // Digit 0 is never blanked so a zero result still shows "0".
    localparam logic [DIGITS-1:0] BlankRst = ~(DIGITS'(1));

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e                state_q, state_d;
    logic [INPUT_BITS-1:0] operand_q, operand_d;
    logic [SW-1:0]         scratch_q, scratch_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [SW-1:0]         bcd_q, bcd_d;
    logic [DIGITS-1:0]     blank_q, blank_d;
    logic                  done_q, done_d;

    logic [SW-1:0]         corrected;
    logic [SW-1:0]         shifted;
    logic [DIGITS-1:0]     blank_next;
    logic                  seen_nonzero;
    logic                  unused_msb;

    // One double dabble iteration: add 3 to every digit >= 5, then shift in the operand MSB.
    always_comb begin
        corrected = scratch_q;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (scratch_q[4*d +: 4] >= 4'd5) begin
                corrected[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
            end
        end
        shifted = {corrected[SW-2:0], operand_q[INPUT_BITS-1]};
    end

    // With legal parameters the corrected MSB is always zero before the shift.
    assign unused_msb = corrected[SW-1];

    // Blank digit n when it and all higher digits of the final result are zero.
    always_comb begin
        seen_nonzero = 1'b0;
        blank_next   = '0;
        for (int d = int'(DIGITS) - 1; d >= 1; d--) begin
            seen_nonzero  = seen_nonzero | (shifted[4*d +: 4] != 4'd0);
            blank_next[d] = ~seen_nonzero;
        end
    end

    // Next-state logic for the IDLE/SHIFT sequencer and its datapath registers.
    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        scratch_d = scratch_q;
        count_d   = count_q;
        bcd_d     = bcd_q;
        blank_d   = blank_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start_i) begin
                    operand_d = bus.binary_i;
                    scratch_d = '0;
                    count_d   = CntW'(INPUT_BITS);
                    state_d   = StShift;
                end
            end
            StShift: begin
                operand_d = {operand_q[INPUT_BITS-2:0], 1'b0};
                scratch_d = shifted;
                count_d   = count_q - CntW'(1);
                if (count_q == CntW'(1)) begin
                    bcd_d   = shifted;
                    blank_d = blank_next;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register; synchronous reset aborts any conversion in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            operand_q <= '0;
            scratch_q <= '0;
            count_q   <= '0;
            bcd_q     <= '0;
            blank_q   <= BlankRst;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            scratch_q <= scratch_d;
            count_q   <= count_d;
            bcd_q     <= bcd_d;
            blank_q   <= blank_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy_o  = (state_q == StShift);
    assign bus.done_o  = done_q;
    assign bus.bcd_o   = bcd_q;
    assign bus.blank_o = blank_q;

endmodule
